// File: rtl/demux_1_to_2_stream_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one input stream and two
// output channels (A and B), each with valid/ready/last handshake.
interface demux_1_to_2_stream_if #(
    parameter int DATA_W = 8
);
    // Input stream
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_sel;
    logic              in_ready;

    // Output channel A
    logic [DATA_W-1:0] out_a_data;
    logic              out_a_valid;
    logic              out_a_last;
    logic              out_a_ready;

    // Output channel B
    logic [DATA_W-1:0] out_b_data;
    logic              out_b_valid;
    logic              out_b_last;
    logic              out_b_ready;

    // Environment side: produces the input stream, consumes both outputs
    modport master (
        output in_data, in_valid, in_last, in_sel,
        input  in_ready,
        input  out_a_data, out_a_valid, out_a_last,
        output out_a_ready,
        input  out_b_data, out_b_valid, out_b_last,
        output out_b_ready
    );

    // Demultiplexer side
    modport slave (
        input  in_data, in_valid, in_last, in_sel,
        output in_ready,
        output out_a_data, out_a_valid, out_a_last,
        input  out_a_ready,
        output out_b_data, out_b_valid, out_b_last,
        input  out_b_ready
    );
endinterface

// File: rtl/demux_1_to_2_stream.sv
// Registered 1-to-2 stream demultiplexer. The route is chosen from in_sel on
// the first beat of a packet and held until the last beat is accepted. Each
// output channel has a single output register; per-channel counters track
// the number of packets whose last beat entered that channel.
module demux_1_to_2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    demux_1_to_2_stream_if.slave s_if,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     pkt_cnt_a_o,
    output logic [CNT_W-1:0]     pkt_cnt_b_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_A = 2'd1,
        ROUTE_B = 2'd2
    } state_e;

    state_e            state_q;
    logic              busy_q;

    logic [DATA_W-1:0] a_data_q;
    logic              a_valid_q;
    logic              a_last_q;
    logic [DATA_W-1:0] b_data_q;
    logic              b_valid_q;
    logic              b_last_q;
    logic [CNT_W-1:0]  cnt_a_q;
    logic [CNT_W-1:0]  cnt_b_q;

    logic              route_b;
    logic              in_ready;
    logic              accept;
    logic              load_a;
    logic              load_b;

    // Effective route: live select while idle, locked channel mid-packet
    assign route_b  = (state_q == IDLE) ? s_if.in_sel : (state_q == ROUTE_B);
    assign in_ready = route_b ? (!b_valid_q || s_if.out_b_ready)
                              : (!a_valid_q || s_if.out_a_ready);
    assign accept   = s_if.in_valid && in_ready;
    assign load_a   = accept && !route_b;
    assign load_b   = accept && route_b;

    // Route-lock FSM with registered busy flag
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!s_if.in_last) begin
                        state_q <= s_if.in_sel ? ROUTE_B : ROUTE_A;
                        busy_q  <= 1'b1;
                    end
                end
                ROUTE_A, ROUTE_B: begin
                    if (s_if.in_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Channel A output register: load on routed accept, drain on ready
    // NOTE: data/last are reset as well because their reset value of zero is
    // visible on the outputs, not just a don't-care behind valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_last_q  <= 1'b0;
        end else if (load_a) begin
            a_valid_q <= 1'b1;
            a_data_q  <= s_if.in_data;
            a_last_q  <= s_if.in_last;
        end else if (s_if.out_a_ready) begin
            a_valid_q <= 1'b0;
        end
    end

    // Channel B output register: load on routed accept, drain on ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_last_q  <= 1'b0;
        end else if (load_b) begin
            b_valid_q <= 1'b1;
            b_data_q  <= s_if.in_data;
            b_last_q  <= s_if.in_last;
        end else if (s_if.out_b_ready) begin
            b_valid_q <= 1'b0;
        end
    end

    // Packet counters: bump when a last beat is accepted into the channel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (load_a && s_if.in_last) cnt_a_q <= cnt_a_q + CNT_W'(1);
            if (load_b && s_if.in_last) cnt_b_q <= cnt_b_q + CNT_W'(1);
        end
    end

    assign s_if.in_ready    = in_ready;
    assign s_if.out_a_data  = a_data_q;
    assign s_if.out_a_valid = a_valid_q;
    assign s_if.out_a_last  = a_last_q;
    assign s_if.out_b_data  = b_data_q;
    assign s_if.out_b_valid = b_valid_q;
    assign s_if.out_b_last  = b_last_q;
    assign busy_o           = busy_q;
    assign pkt_cnt_a_o      = cnt_a_q;
    assign pkt_cnt_b_o      = cnt_b_q;

endmodule

// File: tb/tb_demux_1_to_2_stream.sv
// Directed bench for demux_1_to_2_stream: a vector table for single-cycle
// behaviour plus hand-written sequences for streaming, counter wrap and
// mid-packet reset. Counters are 4 bits wide so wrap is reachable.
module tb_demux_1_to_2_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             busy;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1_to_2_stream_if #(.DATA_W(DATA_W)) bus ();

    demux_1_to_2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_if        (bus.slave),
        .busy_o      (busy),
        .pkt_cnt_a_o (cnt_a),
        .pkt_cnt_b_o (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             sel;
        logic             valid;
        logic [7:0]       data;
        logic             last;
        logic             a_rdy;
        logic             b_rdy;
        logic             exp_rdy;
        logic             exp_av;
        logic [7:0]       exp_ad;
        logic             exp_al;
        logic             exp_bv;
        logic [7:0]       exp_bd;
        logic             exp_bl;
        logic             exp_busy;
        logic [CNT_W-1:0] exp_ca;
        logic [CNT_W-1:0] exp_cb;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sel, input logic valid, input logic [7:0] data,
                         input logic last, input logic a_rdy, input logic b_rdy);
        bus.in_sel      = sel;
        bus.in_valid    = valid;
        bus.in_data     = data;
        bus.in_last     = last;
        bus.out_a_ready = a_rdy;
        bus.out_b_ready = b_rdy;
    endtask

    // Advance to one time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [CNT_W-1:0] exp_ca;

    initial begin
        // sel valid data last ar br | rdy av ad al bv bd bl busy ca cb
        vecs[0]  = '{1,1,8'hA5,1,1,1, 1, 0,8'h00,0, 1,8'hA5,1, 0, 0,1};
        vecs[1]  = '{0,1,8'h11,0,1,1, 1, 1,8'h11,0, 0,8'hA5,1, 1, 0,1};
        vecs[2]  = '{1,1,8'h22,0,1,1, 1, 1,8'h22,0, 0,8'hA5,1, 1, 0,1};
        vecs[3]  = '{1,1,8'h33,1,1,1, 1, 1,8'h33,1, 0,8'hA5,1, 0, 1,1};
        vecs[4]  = '{0,0,8'h00,0,1,1, 1, 0,8'h33,1, 0,8'hA5,1, 0, 1,1};
        vecs[5]  = '{0,1,8'h44,0,0,1, 1, 1,8'h44,0, 0,8'hA5,1, 1, 1,1};
        vecs[6]  = '{0,1,8'h55,1,0,1, 0, 1,8'h44,0, 0,8'hA5,1, 1, 1,1};
        vecs[7]  = '{1,1,8'h55,1,0,1, 0, 1,8'h44,0, 0,8'hA5,1, 1, 1,1};
        vecs[8]  = '{0,1,8'h55,1,0,1, 0, 1,8'h44,0, 0,8'hA5,1, 1, 1,1};
        vecs[9]  = '{0,1,8'h55,1,0,1, 0, 1,8'h44,0, 0,8'hA5,1, 1, 1,1};
        vecs[10] = '{0,1,8'h55,1,1,1, 1, 1,8'h55,1, 0,8'hA5,1, 0, 2,1};
        vecs[11] = '{0,0,8'h00,0,1,1, 1, 0,8'h55,1, 0,8'hA5,1, 0, 2,1};
        vecs[12] = '{0,1,8'h66,1,0,1, 1, 1,8'h66,1, 0,8'hA5,1, 0, 3,1};
        vecs[13] = '{0,1,8'h77,1,0,0, 0, 1,8'h66,1, 0,8'hA5,1, 0, 3,1};
        vecs[14] = '{1,1,8'h77,1,0,0, 1, 1,8'h66,1, 1,8'h77,1, 0, 3,2};
        vecs[15] = '{0,0,8'h00,0,1,1, 1, 0,8'h66,1, 0,8'h77,1, 0, 3,2};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        step();

        // Reset state
        check("rst_a_valid", bus.out_a_valid, 0);
        check("rst_b_valid", bus.out_b_valid, 0);
        check("rst_a_data",  bus.out_a_data,  0);
        check("rst_b_last",  bus.out_b_last,  0);
        check("rst_busy",    busy,            0);
        check("rst_cnt_a",   cnt_a,           0);
        check("rst_cnt_b",   cnt_b,           0);
        rst_n = 1'b1;

        // Table: single beat to B, 3-beat locked packet to A, A stall, IDLE select
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].last,
                  vecs[i].a_rdy, vecs[i].b_rdy);
            #1;
            check($sformatf("v%0d_in_ready", i), bus.in_ready, vecs[i].exp_rdy);
            step();
            check($sformatf("v%0d_a_valid", i), bus.out_a_valid, vecs[i].exp_av);
            check($sformatf("v%0d_a_data", i),  bus.out_a_data,  vecs[i].exp_ad);
            check($sformatf("v%0d_a_last", i),  bus.out_a_last,  vecs[i].exp_al);
            check($sformatf("v%0d_b_valid", i), bus.out_b_valid, vecs[i].exp_bv);
            check($sformatf("v%0d_b_data", i),  bus.out_b_data,  vecs[i].exp_bd);
            check($sformatf("v%0d_b_last", i),  bus.out_b_last,  vecs[i].exp_bl);
            check($sformatf("v%0d_busy", i),    busy,            vecs[i].exp_busy);
            check($sformatf("v%0d_cnt_a", i),   cnt_a,           vecs[i].exp_ca);
            check($sformatf("v%0d_cnt_b", i),   cnt_b,           vecs[i].exp_cb);
        end

        // 8 back-to-back beats to B; select toggles after beat 1 and must be ignored
        for (int i = 0; i < 8; i++) begin
            drive((i == 0) ? 1'b1 : i[0], 1'b1, 8'hB0 + 8'(i), (i == 7), 1'b1, 1'b1);
            #1;
            check($sformatf("burst%0d_in_ready", i), bus.in_ready, 1);
            step();
            check($sformatf("burst%0d_b_valid", i), bus.out_b_valid, 1);
            check($sformatf("burst%0d_b_data", i),  bus.out_b_data,  32'hB0 + i);
            check($sformatf("burst%0d_b_last", i),  bus.out_b_last,  (i == 7));
            check($sformatf("burst%0d_a_valid", i), bus.out_a_valid, 0);
            check($sformatf("burst%0d_busy", i),    busy,            (i != 7));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        check("burst_drain_b_valid", bus.out_b_valid, 0);
        check("burst_cnt_b", cnt_b, 3);

        // 16 single-beat packets to A from a fresh reset: counter wraps to 0
        do_reset();
        exp_ca = '0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b1, 1'b1, 1'b1);
            step();
            exp_ca = exp_ca + 1'b1;
            check($sformatf("wrap%0d_cnt_a", i), cnt_a, exp_ca);
            check($sformatf("wrap%0d_a_data", i), bus.out_a_data, i);
        end
        check("wrap_final_cnt_a", cnt_a, 0);
        check("wrap_cnt_b", cnt_b, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();

        // Reset during beat 2 of a 4-beat A packet
        drive(1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b1);
        step();
        check("mid_busy_before", busy, 1);
        check("mid_a_valid_before", bus.out_a_valid, 1);
        drive(1'b1, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", bus.out_a_valid, 0);
        check("mid_rst_b_valid", bus.out_b_valid, 0);
        check("mid_rst_busy",    busy,            0);
        check("mid_rst_a_data",  bus.out_a_data,  0);
        check("mid_rst_cnt_a",   cnt_a,           0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 8'hD1, 1'b1, 1'b1, 1'b1);
        step();
        check("post_rst_b_valid", bus.out_b_valid, 1);
        check("post_rst_b_data",  bus.out_b_data,  32'hD1);
        check("post_rst_a_valid", bus.out_a_valid, 0);
        check("post_rst_busy",    busy,            0);
        check("post_rst_cnt_b",   cnt_b,           1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
